// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   Decoupling queue between instruction fetch and decode. Holds up to DEPTH
//   (pc, inst) pairs, FIFO order, valid/ready handshakes on both sides.
//   An empty head presents a zero bubble (pc=0, inst=0).
//   A flush empties the queue. If fetch still has a request in flight on the
//   flush edge, that stale beat is accepted later and discarded.
//
// Optional build macro:
//   IF_ID_QUEUE_BYPASS_EN - when the queue is empty, an incoming beat is
//   forwarded combinationally to the head outputs (0-cycle latency). If
//   decode consumes it in the same cycle, it is never written to storage.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard all entries (redirect from id/exe)
//   fetch_busy        fetch has a request outstanding this cycle
//   in_valid/ready    fetch-side handshake; in_pc, in_inst carry the beat
//   stall             decode hold; blocks pops
//   out_valid/ready   decode-side handshake; out_pc, out_inst are the head
//   count/full/empty  occupancy status
//   drop_pending      next accepted beat will be discarded
// ---------------------------------------------------------------------------
module if_id_queue #(
   parameter int PC_W   = 64,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         fetch_busy,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [PC_W-1:0]              in_pc,
   input  logic [INST_W-1:0]            in_inst,
   input  logic                         stall,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PC_W-1:0]              out_pc,
   output logic [INST_W-1:0]            out_inst,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic                         drop_pending
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [PC_W-1:0]   pc_mem_q   [DEPTH];
   logic [INST_W-1:0] inst_mem_q [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          drop_q,   drop_d;

   logic accept;     // beat taken from fetch (written or dropped)
   logic push;       // beat accepted for storage/consumption
   logic pop;        // head consumed by decode
   logic byp;        // head is the live input beat (bypass build only)
   logic wr_en;      // storage write
   logic rd_en;      // read pointer advance
   logic head_vld;   // storage holds at least one entry

   assign head_vld     = (count_q != '0);
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = !head_vld;
   assign count        = count_q;
   assign drop_pending = drop_q;
   assign in_ready     = !rst && !full;

   assign accept = in_valid && in_ready && !flush;
   assign push   = accept && !drop_q;

`ifdef IF_ID_QUEUE_BYPASS_EN
   assign byp = !rst && empty && in_valid && !drop_q && !flush;
`else
   assign byp = 1'b0;
`endif

   assign out_valid = head_vld || byp;
   assign pop       = out_valid && out_ready && !stall && !flush;

   // A bypassed beat consumed in the same cycle never touches storage.
   assign wr_en = push && !(byp && pop);
   assign rd_en = pop  && !(byp && pop);

   always_comb begin
      out_pc   = '0;
      out_inst = '0;
      if (head_vld) begin
         out_pc   = pc_mem_q[rd_ptr_q];
         out_inst = inst_mem_q[rd_ptr_q];
      end else if (byp) begin
         out_pc   = in_pc;
         out_inst = in_inst;
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         // A request still in flight will return a beat from the old path.
         drop_d   = fetch_busy;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (drop_q && accept) drop_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   // Storage carries data only; validity is tracked by count/pointers.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         pc_mem_q[wr_ptr_q]   <= in_pc;
         inst_mem_q[wr_ptr_q] <= in_inst;
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

   localparam int PC_W   = 64;
   localparam int INST_W = 32;
   localparam int DEPTH  = 4;
   localparam int CW     = $clog2(DEPTH+1);
`ifdef IF_ID_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              fetch_busy = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc = '0;
   logic [INST_W-1:0] in_inst = '0;
   logic              stall = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [PC_W-1:0]   out_pc;
   logic [INST_W-1:0] out_inst;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;
   logic              drop_pending;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: an ideal FIFO plus the drop flag.
   logic [PC_W-1:0]   mq_pc[$];
   logic [INST_W-1:0] mq_inst[$];
   bit                m_drop = 1'b0;

   if_id_queue #(.PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .fetch_busy(fetch_busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .count(count), .full(full),
      .empty(empty), .drop_pending(drop_pending)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then
   // advance the model across the rising edge.
   task automatic step(input bit r, input bit fl, input bit fb, input bit iv,
                       input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                       input bit st, input bit ordy);
      int   sz;
      bit   e_full, e_rdy, e_byp, e_ov, e_pop, e_acc;
      logic [PC_W-1:0]   e_pc;
      logic [INST_W-1:0] e_inst;
      @(negedge clk);
      rst = r; flush = fl; fetch_busy = fb; in_valid = iv;
      in_pc = pc; in_inst = inst; stall = st; out_ready = ordy;
      #1;
      sz     = mq_pc.size();
      e_full = (sz == DEPTH);
      e_rdy  = !r && !e_full;
      e_byp  = BYP && !r && (sz == 0) && iv && !m_drop && !fl;
      e_ov   = (sz != 0) || e_byp;
      e_pc   = (sz != 0) ? mq_pc[0]   : (e_byp ? pc   : '0);
      e_inst = (sz != 0) ? mq_inst[0] : (e_byp ? inst : '0);
      check_eq("out_valid",    64'(out_valid),    64'(e_ov));
      check_eq("out_pc",       64'(out_pc),       64'(e_pc));
      check_eq("out_inst",     64'(out_inst),     64'(e_inst));
      check_eq("count",        64'(count),        64'(sz));
      check_eq("full",         64'(full),         64'(e_full));
      check_eq("empty",        64'(empty),        64'(sz == 0));
      check_eq("in_ready",     64'(in_ready),     64'(e_rdy));
      check_eq("drop_pending", 64'(drop_pending), 64'(m_drop));
      e_pop = e_ov && ordy && !st && !fl;
      e_acc = iv && e_rdy && !fl;
      @(posedge clk);
      if (r) begin
         mq_pc.delete(); mq_inst.delete(); m_drop = 1'b0;
      end else if (fl) begin
         mq_pc.delete(); mq_inst.delete(); m_drop = fb;
      end else begin
         if (e_acc && m_drop) begin
            m_drop = 1'b0;
            e_acc  = 1'b0;
         end
         if (!(e_byp && e_pop)) begin
            if (e_pop) begin
               void'(mq_pc.pop_front()); void'(mq_inst.pop_front());
            end
            if (e_acc) begin
               mq_pc.push_back(pc); mq_inst.push_back(inst);
            end
         end
      end
   endtask

   initial begin
      // Bring the DUT out of its unknown power-up state before checking.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      mq_pc.delete(); mq_inst.delete(); m_drop = 1'b0;

      // Reset held: in_ready low, bubble outputs.
      step(1, 0, 0, 1, 64'h1, 32'h1, 0, 0);

      // First push, visible on the head afterwards.
      step(0, 0, 0, 1, 64'h8000_0000, 32'h0000_0013, 0, 0);
      step(0, 0, 0, 0, 64'h0, 32'h0, 0, 0);
      step(0, 1, 0, 0, 64'h0, 32'h0, 0, 0);

      // Fill to full, refused push, then drain in order.
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 64'h100 + 64'(4*i), 32'(i), 0, 0);
      step(0, 0, 0, 1, 64'h110, 32'h9, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 64'h0, 32'h0, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 64'h500 + 64'(4*i), 32'(i), 0, (i % 3) != 0);
      step(0, 1, 0, 0, 64'h0, 32'h0, 0, 0);

      // Simultaneous push/pop at count=2.
      step(0, 0, 0, 1, 64'h600, 32'h60, 0, 0);
      step(0, 0, 0, 1, 64'h604, 32'h61, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 64'h608 + 64'(4*i), 32'(i), 0, 1);

      // Stall with out_ready high: head holds while pushes fill the queue.
      step(0, 0, 0, 1, 64'h700, 32'h70, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 64'h704 + 64'(4*i), 32'(i), 1, 1);

      // Flush with fetch busy at count=3: stale 0x200 dropped, 0x300 kept.
      step(0, 1, 0, 0, 64'h0, 32'h0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 64'h800 + 64'(4*i), 32'(i), 0, 0);
      step(0, 1, 1, 0, 64'h0, 32'h0, 0, 0);
      step(0, 0, 1, 1, 64'h200, 32'h20, 0, 0);
      step(0, 0, 0, 1, 64'h300, 32'h30, 0, 0);
      step(0, 0, 0, 0, 64'h0, 32'h0, 0, 1);

      // Empty queue, beat 0x400 with out_ready=1 (bypass-dependent timing).
      step(0, 0, 0, 1, 64'h400, 32'h40, 0, 1);
      step(0, 0, 0, 0, 64'h0, 32'h0, 0, 1);

      // Mid-operation reset.
      step(0, 0, 0, 1, 64'h900, 32'h90, 0, 0);
      step(1, 1, 1, 1, 64'h904, 32'h91, 0, 0);
      step(0, 0, 0, 0, 64'h0, 32'h0, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 3) != 0),
              {$urandom, $urandom}, $urandom,
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 2) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF/ID decoupling queue; the next generation of the single-entry IF/ID pipeline register.
- Buffers up to DEPTH fetched (pc, inst) pairs between fetch and decode, using valid/ready handshakes on both sides.
- Supports global flush, decode-side stall and discard of one stale in-flight fetch beat after a flush.
- Empty output slot presents a zero bubble (pc=0, inst=0).

Parameters:
- PC_W, 64, width of the pc field.
- INST_W, 32, width of the instruction field.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  redirect from id/exe; discards all entries.
- fetch_busy  input  1  fetch has a request outstanding this cycle.
- in_valid  input  1  fetch beat valid.
- in_ready  output  1  queue can accept a beat.
- in_pc  input  PC_W  pc of the fetch beat.
- in_inst  input  INST_W  instruction of the fetch beat.
- stall  input  1  decode hold; while high, no pop occurs.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes the head.
- out_pc  output  PC_W  head pc; 0 when out_valid=0.
- out_inst  output  INST_W  head instruction; 0 when out_valid=0.
- count  output  $clog2(DEPTH+1)  number of stored entries.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- drop_pending  output  1  next accepted beat will be discarded.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rd_ptr, wr_ptr, count and drop_pending are cleared.
  - Outputs after reset: out_valid=0, out_pc=0, out_inst=0, empty=1, full=0, in_ready=0 while rst is high.
- Handshake rules:
  - in_ready = !rst & !full. It does not depend on out_ready; there is no combinational path between the two sides.
  - push = in_valid & in_ready & !flush & !drop_pending.
  - pop = out_valid & out_ready & !stall & !flush.
- Push/pop update:
  - Push writes entry[wr_ptr] and increments wr_ptr.
  - Pop increments rd_ptr.
  - Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
  - count = count + push - pop.
  - Push and pop in the same cycle leave count unchanged. This is legal at any non-full count, including count=1 (head replaced by next).
- Latency: a beat pushed at edge N is visible on out_* after edge N (registered storage, combinational head read). Minimum fetch-to-decode latency is 1 cycle.
- Head outputs: out_pc/out_inst = entry[rd_ptr] when count!=0, else 0.
- Stall: holds the head stable; pushes continue until full.
- Flush (highest priority after reset):
  - At the edge, count, rd_ptr and wr_ptr are set to 0 and any in-cycle push/pop is suppressed.
  - The next cycle shows out_valid=0 and out_pc/out_inst=0.
- Stale-beat drop:
  - If flush=1 and fetch_busy=1 on the same edge, drop_pending is set.
  - While drop_pending=1, the first beat with in_valid & in_ready is accepted but not written, and drop_pending clears on that edge.
  - A new flush while drop_pending=1 keeps it set if fetch_busy=1, otherwise clears it.
- Full and empty boundaries:
  - A push attempt while full is refused (in_ready=0); the beat must be held by fetch.
  - A pop attempt while empty is impossible (out_valid=0).
- Reset mid-operation discards all entries and drop_pending, with the same result as power-up.

Optional Feature:
- Macro: IF_ID_QUEUE_BYPASS_EN.
- Defined:
  - When empty=1, in_valid=1, drop_pending=0 and flush=0, the input beat is presented combinationally on out_*, with out_valid=1.
  - If it is also popped that cycle (out_ready=1, stall=0), it is not written and count stays 0. Otherwise it is pushed normally.
  - Fetch-to-decode latency is 0 cycles when empty.
- Undefined: out_* come only from storage; minimum latency is 1 cycle.

Test Plan:
- Reset, then push pc=0x8000_0000/inst=0x0000_0013 with out_ready=0 -> next cycle out_valid=1, out_pc=0x8000_0000, count=1.
- Push 4 beats (pc 0x100, 0x104, 0x108, 0x10C), DEPTH=4, out_ready=0 -> full=1, in_ready=0. Then out_ready=1 -> pops in order 0x100..0x10C; pointers wrap on further pushes with no loss.
- Simultaneous push and pop at count=2 for 10 cycles -> count stays 2 and output order is preserved.
- stall=1 with out_ready=1, count=3 -> head unchanged and count rises to 4 if pushes continue; no pop while stall=1.
- flush=1 with fetch_busy=1, count=3 -> next cycle count=0, out_valid=0, drop_pending=1. Next beat pc=0x200 is dropped; following beat pc=0x300 appears at the head.
- Bypass build, empty, in_valid with pc=0x400, out_ready=1 -> out_pc=0x400 in the same cycle and count stays 0. Non-bypass build -> out_pc=0x400 one cycle later.
